axi4_burst_ram_slave: RTL and testbench
=======================================

AXI4_BURST_RAM_SLAVE -- requirements
Module: axi4_burst_ram_slave

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, data bus width in bytes.
REQ-002 SHALL have parameter ADDR_BYTES, default 1, address bus width in bytes; byte-addressed memory of 2^(ADDR_BYTES*8) bytes.
REQ-003 SHALL have parameter NUM_ID_BITS_P, default 4, ID width.
REQ-004 SHALL have parameter NUM_USER_BITS_P, default 4, user width.
REQ-005 SHALL have port aclk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port aresetn  in  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have ports awvalid/awready  in/out  1  AW handshake; awaddr in ADDR_BYTES*8; awlen in 8; awsize in 3; awburst in 2; awid in NUM_ID_BITS_P; awuser in NUM_USER_BITS_P.
REQ-008 SHALL have ports awcache in 4, awprot in 3, awlock in 1, awregion in 4, awqos in 4, and the same five on AR; accepted and ignored.
REQ-009 SHALL have ports wvalid/wready  in/out  1; wdata in DATA_BYTES*8; wstrb in DATA_BYTES; wlast in 1; wuser in NUM_USER_BITS_P (ignored).
REQ-010 SHALL have ports bvalid/bready  out/in  1; bresp out 2; bid out NUM_ID_BITS_P; buser out NUM_USER_BITS_P.
REQ-011 SHALL have ports arvalid/arready  in/out  1; araddr, arlen, arsize, arburst, arid, aruser, widths as AW.
REQ-012 SHALL have ports rvalid/rready  out/in  1; rdata out DATA_BYTES*8; rresp out 2; rlast out 1; rid out NUM_ID_BITS_P; ruser out NUM_USER_BITS_P.

Function
REQ-013 SHALL run independent write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA); handshake = valid && ready on a rising edge.
REQ-014 W_IDLE: awready=1; on AW handshake latch addr/len/size/burst/id, clear beat count and error flag, go W_DATA.
REQ-015 W_DATA: wready=1; each W handshake writes bytes with wstrb[i]=1 at current word, increments beat count, advances address; handshake of beat awlen+1 goes W_RESP.
REQ-016 W_RESP: bvalid=1, bid=latched awid, buser=0, bresp=00 OKAY or 10 SLVERR if error flag set; hold until bready, then W_IDLE.
REQ-017 R_IDLE: arready=1; on AR handshake latch fields, go R_DATA; first rvalid the cycle after handshake.
REQ-018 R_DATA: rvalid=1, rdata=memory word at current address, rid=latched arid, ruser=0, rlast=1 only on beat arlen+1; outputs stable while rready=0; on final handshake go R_IDLE.
REQ-019 Burst 00 FIXED: address constant; 01 INCR: +DATA_BYTES per beat, modulo memory size; 10 WRAP: wraps within (len+1)*DATA_BYTES aligned boundary.
REQ-020 Error conditions: burst 11, size != log2(DATA_BYTES), or WRAP with len not in {1,3,7,15}; write bursts suppress all memory writes, read bursts return rdata=0; full beat count still honoured; response SLVERR (every R beat).
REQ-021 wlast value mismatching beat count sets write error flag (SLVERR) but does not change burst length.
REQ-022 Low log2(DATA_BYTES) address bits SHALL be ignored for word selection.
REQ-023 Same-cycle read and write to same word: rdata shows pre-write value; new value visible next cycle.
REQ-024 awready and wready SHALL never both be 1; at most one outstanding write and one read burst.

Reset
REQ-025 aresetn=0 SHALL immediately force W_IDLE, R_IDLE: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=00, bid=rid=0, rdata=0.
REQ-026 Memory contents SHALL NOT be reset; beats written before mid-burst reset remain.

Verification
REQ-027 INCR write, awaddr=0x00, awlen=9, 10 random words, wstrb=F -> 10 wready handshakes, one bvalid with bresp=00, bid=awid; INCR read arlen=9 returns same 10 words, rlast on beat 10 only.
REQ-028 FIXED read araddr=0x00, arlen=7, arburst=00 -> 8 beats all equal word 0, rresp=00, rlast on beat 8.
REQ-029 WRAP write awaddr=0x08, awlen=3 -> words at 0x08,0x0C,0x00,0x04; readback confirms.
REQ-030 wstrb=0x3 writing 0xAABBCCDD over 0x11223344 -> readback 0x1122CCDD; rready held low 3 cycles -> rdata/rlast stable.
REQ-031 awburst=11 or awsize=1 -> all beats accepted, bresp=10, memory unchanged; arburst=11 -> rdata=0, rresp=10 each beat.
REQ-032 aresetn low during beat 3 of 8-beat write -> bvalid never asserted, awready=1 immediately; beats 1-2 retained, readable after reset.

Source files
------------

// File: rtl/axi4_burst_ram_slave_if.sv
// AXI4 bus bundle between a burst master and the RAM slave.
// The slave modport sees the full AW/W/B/AR/R channel set, including the sideband fields it ignores.
interface axi4_burst_ram_slave_if #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDR_BYTES      = 1,
  parameter int NUM_ID_BITS_P   = 4,
  parameter int NUM_USER_BITS_P = 4
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int DW = DATA_BYTES * 8;

  logic                       awvalid, awready;
  logic [AW-1:0]              awaddr;
  logic [7:0]                 awlen;
  logic [2:0]                 awsize;
  logic [1:0]                 awburst;
  logic [NUM_ID_BITS_P-1:0]   awid;
  logic [NUM_USER_BITS_P-1:0] awuser;
  logic [3:0]                 awcache, awregion, awqos;
  logic [2:0]                 awprot;
  logic                       awlock;

  logic                       wvalid, wready;
  logic [DW-1:0]              wdata;
  logic [DATA_BYTES-1:0]      wstrb;
  logic                       wlast;
  logic [NUM_USER_BITS_P-1:0] wuser;

  logic                       bvalid, bready;
  logic [1:0]                 bresp;
  logic [NUM_ID_BITS_P-1:0]   bid;
  logic [NUM_USER_BITS_P-1:0] buser;

  logic                       arvalid, arready;
  logic [AW-1:0]              araddr;
  logic [7:0]                 arlen;
  logic [2:0]                 arsize;
  logic [1:0]                 arburst;
  logic [NUM_ID_BITS_P-1:0]   arid;
  logic [NUM_USER_BITS_P-1:0] aruser;
  logic [3:0]                 arcache, arregion, arqos;
  logic [2:0]                 arprot;
  logic                       arlock;

  logic                       rvalid, rready;
  logic [DW-1:0]              rdata;
  logic [1:0]                 rresp;
  logic                       rlast;
  logic [NUM_ID_BITS_P-1:0]   rid;
  logic [NUM_USER_BITS_P-1:0] ruser;

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid, awuser,
           awcache, awprot, awlock, awregion, awqos,
           wvalid, wdata, wstrb, wlast, wuser, bready,
           arvalid, araddr, arlen, arsize, arburst, arid, aruser,
           arcache, arprot, arlock, arregion, arqos, rready,
    output awready, wready, bvalid, bresp, bid, buser,
           arready, rvalid, rdata, rresp, rlast, rid, ruser
  );

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid, awuser,
           awcache, awprot, awlock, awregion, awqos,
           wvalid, wdata, wstrb, wlast, wuser, bready,
           arvalid, araddr, arlen, arsize, arburst, arid, aruser,
           arcache, arprot, arlock, arregion, arqos, rready,
    input  awready, wready, bvalid, bresp, bid, buser,
           arready, rvalid, rdata, rresp, rlast, rid, ruser
  );
endinterface

// File: rtl/axi4_burst_ram_slave.sv
// Byte-addressed AXI4 RAM slave with independent single-outstanding write and read burst engines.
// Supports FIXED/INCR/WRAP bursts; illegal bursts complete with full beat count and SLVERR.
module axi4_burst_ram_slave #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDR_BYTES      = 1,
  parameter int NUM_ID_BITS_P   = 4,
  parameter int NUM_USER_BITS_P = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axi4_burst_ram_slave_if.slave   bus
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int DW = DATA_BYTES * 8;
  localparam int LB = $clog2(DATA_BYTES);
  localparam int NW = (2 ** AW) / DATA_BYTES;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                              input logic [1:0] burst);
    logic [AW-1:0] mask;
    mask = (AW'(len) + AW'(1)) * AW'(DATA_BYTES) - AW'(1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + AW'(DATA_BYTES)) & mask);
      default: next_addr = a + AW'(DATA_BYTES);
    endcase
  endfunction

  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_bad;
    wrap_bad  = (burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    burst_err = (burst == 2'b11) || (size != 3'(LB)) || wrap_bad;
  endfunction

  logic [DW-1:0] mem [NW];

  w_state_t                 w_state, w_state_nx;
  logic [AW-1:0]            w_addr;
  logic [7:0]               w_len, w_cnt;
  logic [1:0]               w_burst;
  logic [NUM_ID_BITS_P-1:0] w_id;
  logic                     w_cfg_err, w_last_err;
  logic                     aw_rdy, w_rdy, b_vld, aw_hs, w_hs;

  r_state_t                 r_state, r_state_nx;
  logic [AW-1:0]            r_addr;
  logic [7:0]               r_len, r_cnt;
  logic [1:0]               r_burst;
  logic [NUM_ID_BITS_P-1:0] r_id;
  logic                     r_err;
  logic                     ar_rdy, r_vld, ar_hs, r_hs;

  assign aw_hs = aw_rdy & bus.awvalid;
  assign w_hs  = w_rdy  & bus.wvalid;
  assign ar_hs = ar_rdy & bus.arvalid;
  assign r_hs  = r_vld  & bus.rready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    aw_rdy     = 1'b0;
    w_rdy      = 1'b0;
    b_vld      = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_rdy = 1'b1;
        if (bus.awvalid) w_state_nx = W_DATA;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (bus.wvalid && w_cnt == w_len) w_state_nx = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (bus.bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_addr     <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_burst    <= '0;
      w_id       <= '0;
      w_cfg_err  <= 1'b0;
      w_last_err <= 1'b0;
    end else if (aw_hs) begin
      w_addr     <= bus.awaddr;
      w_len      <= bus.awlen;
      w_cnt      <= '0;
      w_burst    <= bus.awburst;
      w_id       <= bus.awid;
      w_cfg_err  <= burst_err(bus.awlen, bus.awsize, bus.awburst);
      w_last_err <= 1'b0;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      // wlast is only checked; the burst length always comes from awlen
      if (bus.wlast != (w_cnt == w_len)) w_last_err <= 1'b1;
    end
  end

  // Memory deliberately has no reset so data survives a mid-burst reset
  always_ff @(posedge aclk) begin
    if (w_hs && !w_cfg_err) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (bus.wstrb[i]) mem[w_addr[AW-1:LB]][i*8 +: 8] <= bus.wdata[i*8 +: 8];
      end
    end
  end

  assign bus.awready = aw_rdy;
  assign bus.wready  = w_rdy;
  assign bus.bvalid  = b_vld;
  assign bus.bresp   = (b_vld && (w_cfg_err || w_last_err)) ? 2'b10 : 2'b00;
  assign bus.bid     = b_vld ? w_id : '0;
  assign bus.buser   = '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    ar_rdy     = 1'b0;
    r_vld      = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_rdy = 1'b1;
        if (bus.arvalid) r_state_nx = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (bus.rready && r_cnt == r_len) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else if (ar_hs) begin
      r_addr  <= bus.araddr;
      r_len   <= bus.arlen;
      r_cnt   <= '0;
      r_burst <= bus.arburst;
      r_id    <= bus.arid;
      r_err   <= burst_err(bus.arlen, bus.arsize, bus.arburst);
    end else if (r_hs) begin
      r_addr <= next_addr(r_addr, r_len, r_burst);
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Combinational read: a same-cycle write to this word shows up one cycle later
  assign bus.arready = ar_rdy;
  assign bus.rvalid  = r_vld;
  assign bus.rdata   = (r_vld && !r_err) ? mem[r_addr[AW-1:LB]] : '0;
  assign bus.rresp   = (r_vld && r_err) ? 2'b10 : 2'b00;
  assign bus.rlast   = r_vld && (r_cnt == r_len);
  assign bus.rid     = r_vld ? r_id : '0;
  assign bus.ruser   = '0;

  logic unused_sideband;
  assign unused_sideband = ^{bus.awuser, bus.awcache, bus.awprot, bus.awlock, bus.awregion,
                             bus.awqos, bus.wuser, bus.aruser, bus.arcache, bus.arprot,
                             bus.arlock, bus.arregion, bus.arqos};
endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Scoreboard bench for axi4_burst_ram_slave: drivers queue expected B/R responses,
// a negedge monitor pops and compares them whenever a response handshake is presented.
`timescale 1ns/1ps
module tb_axi4_burst_ram_slave;
  localparam int DB = 4, AB = 1, IDW = 4, UW = 4;

  typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi4_burst_ram_slave_if #(.DATA_BYTES(DB), .ADDR_BYTES(AB), .NUM_ID_BITS_P(IDW),
                            .NUM_USER_BITS_P(UW)) bus ();
  axi4_burst_ram_slave #(.DATA_BYTES(DB), .ADDR_BYTES(AB), .NUM_ID_BITS_P(IDW),
                         .NUM_USER_BITS_P(UW)) dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  int          n_cmp = 0, n_err = 0, w_beats = 0;
  logic [31:0] model [64];
  logic [31:0] wbuf  [16];
  logic [31:0] rexp  [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake at %0t", name, $time);
  endtask

  always @(negedge aclk) begin
    if (aresetn) begin
      chk("aw_w_exclusive", 64'(bus.awready & bus.wready), 64'd0);
      if (bus.bvalid && bus.bready) begin
        if (b_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_b: bresp=%0d bid=%0d with no response expected", bus.bresp, bus.bid);
        end else begin
          b_exp_t e;
          e = b_q.pop_front();
          chk("bresp", 64'(bus.bresp), 64'(e.resp));
          chk("bid",   64'(bus.bid),   64'(e.id));
          chk("buser", 64'(bus.buser), 64'd0);
        end
      end
      if (bus.rvalid && bus.rready) begin
        if (r_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_r: rdata=0x%0h with no beat expected", bus.rdata);
        end else begin
          r_exp_t e;
          e = r_q.pop_front();
          chk("rdata", 64'(bus.rdata), 64'(e.data));
          chk("rresp_rlast_rid", 64'({bus.rresp, bus.rlast, bus.rid}), 64'({e.resp, e.last, e.id}));
          chk("ruser", 64'(bus.ruser), 64'd0);
        end
      end
    end
  end

  task automatic send_aw(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    logic hs;
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk); hs = bus.awready;
      @(posedge aclk); #1;
      if (hs) break;
      if (n == 49) timeout_fail("aw_handshake");
    end
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    logic hs;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk); hs = bus.wready;
      @(posedge aclk); #1;
      if (hs) begin w_beats++; break; end
      if (n == 49) timeout_fail("w_handshake");
    end
    bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    logic hs;
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk); hs = bus.arready;
      @(posedge aclk); #1;
      if (hs) break;
      if (n == 49) timeout_fail("ar_handshake");
    end
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300; n++) begin
      if (b_q.size() == 0 && r_q.size() == 0) break;
      @(posedge aclk); #1;
      if (n == 299) timeout_fail("response_drain");
    end
  endtask

  task automatic write_burst(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input logic [3:0] strb,
                             input logic [1:0] resp, input logic bad_last);
    b_exp_t e;
    e.resp = resp; e.id = id;
    b_q.push_back(e);
    send_aw(addr, len, size, burst, id);
    for (int i = 0; i <= int'(len); i++) send_w(wbuf[i], strb, (i == int'(len)) && !bad_last);
    wait_drain();
  endtask

  task automatic read_burst(input logic [7:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input logic [1:0] resp);
    r_exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = rexp[i]; e.resp = resp; e.last = (i == int'(len)); e.id = id;
      r_q.push_back(e);
    end
    send_ar(addr, len, size, burst, id);
    wait_drain();
  endtask

  initial begin
    logic seen_b;
    logic [31:0] old0, old1;
    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0; bus.awid = 0;
    bus.awuser = 0; bus.awcache = 0; bus.awprot = 0; bus.awlock = 0; bus.awregion = 0; bus.awqos = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wuser = 0; bus.bready = 1;
    bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0; bus.arid = 0;
    bus.aruser = 0; bus.arcache = 0; bus.arprot = 0; bus.arlock = 0; bus.arregion = 0; bus.arqos = 0;
    bus.rready = 1;

    #1 aresetn = 1'b0;
    #11;
    chk("rst_awready", 64'(bus.awready), 64'd1);
    chk("rst_arready", 64'(bus.arready), 64'd1);
    chk("rst_wready",  64'(bus.wready),  64'd0);
    chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
    chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
    chk("rst_rlast",   64'(bus.rlast),   64'd0);
    chk("rst_resp",    64'({bus.bresp, bus.rresp}), 64'd0);
    chk("rst_ids",     64'({bus.bid, bus.rid}), 64'd0);
    chk("rst_rdata",   64'(bus.rdata),   64'd0);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;

    // INCR 10-beat write then readback
    for (int i = 0; i < 10; i++) begin wbuf[i] = $urandom; model[i] = wbuf[i]; end
    w_beats = 0;
    write_burst(8'h00, 8'd9, 3'd2, 2'b01, 4'd5, 4'hF, 2'b00, 1'b0);
    chk("incr_w_beats", 64'(w_beats), 64'd10);
    for (int i = 0; i < 10; i++) rexp[i] = model[i];
    read_burst(8'h00, 8'd9, 3'd2, 2'b01, 4'd3, 2'b00);

    // FIXED read of word 0
    for (int i = 0; i < 8; i++) rexp[i] = model[0];
    read_burst(8'h00, 8'd7, 3'd2, 2'b00, 4'd2, 2'b00);

    // WRAP write at 0x08: order 0x08, 0x0C, 0x00, 0x04
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    model[2] = wbuf[0]; model[3] = wbuf[1]; model[0] = wbuf[2]; model[1] = wbuf[3];
    write_burst(8'h08, 8'd3, 3'd2, 2'b10, 4'd6, 4'hF, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) rexp[i] = model[i];
    read_burst(8'h00, 8'd3, 3'd2, 2'b01, 4'd1, 2'b00);
    rexp[0] = model[2]; rexp[1] = model[3]; rexp[2] = model[0]; rexp[3] = model[1];
    read_burst(8'h08, 8'd3, 3'd2, 2'b10, 4'd4, 2'b00);

    // Byte strobes plus stalled read
    wbuf[0] = 32'h1122_3344;
    write_burst(8'h20, 8'd0, 3'd2, 2'b01, 4'd7, 4'hF, 2'b00, 1'b0);
    wbuf[0] = 32'hAABB_CCDD;
    write_burst(8'h20, 8'd0, 3'd2, 2'b01, 4'd7, 4'h3, 2'b00, 1'b0);
    model[8] = 32'h1122_CCDD;
    bus.rready = 1'b0;
    begin
      r_exp_t e;
      e.data = 32'h1122_CCDD; e.resp = 2'b00; e.last = 1'b1; e.id = 4'd8;
      r_q.push_back(e);
    end
    send_ar(8'h20, 8'd0, 3'd2, 2'b01, 4'd8);
    for (int n = 0; n < 20; n++) begin
      @(negedge aclk);
      if (bus.rvalid) break;
      if (n == 19) timeout_fail("stall_rvalid");
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge aclk);
      chk("stall_rvalid", 64'(bus.rvalid), 64'd1);
      chk("stall_rdata",  64'(bus.rdata),  64'h1122_CCDD);
      chk("stall_rlast",  64'(bus.rlast),  64'd1);
    end
    @(posedge aclk); #1;
    bus.rready = 1'b1;
    wait_drain();

    // Illegal bursts: writes suppressed, reads return zero, SLVERR throughout
    old0 = model[0]; old1 = model[1];
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hDEAD_0000 + 32'(i);
    write_burst(8'h00, 8'd3, 3'd2, 2'b11, 4'd9, 4'hF, 2'b10, 1'b0);
    write_burst(8'h00, 8'd1, 3'd1, 2'b01, 4'd10, 4'hF, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) rexp[i] = model[i];
    read_burst(8'h00, 8'd3, 3'd2, 2'b01, 4'd11, 2'b00);
    chk("err_mem_word0", 64'(rexp[0]), 64'(old0));
    chk("err_mem_word1", 64'(rexp[1]), 64'(old1));
    for (int i = 0; i < 3; i++) rexp[i] = 32'h0;
    read_burst(8'h00, 8'd2, 3'd2, 2'b11, 4'd12, 2'b10);
    read_burst(8'h08, 8'd2, 3'd2, 2'b10, 4'd13, 2'b10);
    wbuf[0] = 32'h5555_0000; wbuf[1] = 32'h5555_0001;
    write_burst(8'h28, 8'd1, 3'd2, 2'b01, 4'd14, 4'hF, 2'b10, 1'b1);

    // Reset during beat 3 of an 8-beat write
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h5EED_0000 + 32'(i);
    send_aw(8'h40, 8'd7, 3'd2, 2'b01, 4'd9);
    send_w(wbuf[0], 4'hF, 1'b0);
    send_w(wbuf[1], 4'hF, 1'b0);
    model[16] = wbuf[0]; model[17] = wbuf[1];
    bus.wdata = wbuf[2]; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_awready", 64'(bus.awready), 64'd1);
    chk("midrst_wready",  64'(bus.wready),  64'd0);
    chk("midrst_bvalid",  64'(bus.bvalid),  64'd0);
    bus.wvalid = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    seen_b = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      if (bus.bvalid) seen_b = 1'b1;
    end
    chk("midrst_no_bvalid", 64'(seen_b), 64'd0);
    @(posedge aclk); #1;
    rexp[0] = model[16]; rexp[1] = model[17];
    read_burst(8'h40, 8'd1, 3'd2, 2'b01, 4'd15, 2'b00);

    repeat (3) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
